tz_restore16: RTL and testbench
===============================

Name: tz_restore16

Overview:
- Inverse of the trailing-zero counter used in the GCD datapath.
- Takes an odd (or any) operand plus a zero count and re-inserts that many trailing zeros (logical left shift). This restores the common power of two at the end of a binary GCD.
- Two-stage pipelined log shifter with a valid/ready handshake, full throughput, and an overflow flag when set bits are shifted out.

Parameters:
- WIDTH, 16, operand width in bits; power of two, at least 4.
- SW, $clog2(WIDTH)+1, shift-amount width, so that a shift of exactly WIDTH is representable.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input operand valid.
- ready_o  output  1  block can accept an operand this cycle.
- data_i  input  WIDTH  operand to be shifted.
- shamt_i  input  SW  number of zeros to append; legal range 0..2^SW-1.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- data_o  output  WIDTH  (data_i << shamt_i), truncated to WIDTH bits.
- ovf_o  output  1  at least one 1 bit was shifted past the MSB.

Behaviour:
- Reset (async assert, sync release): both stage valids = 0, valid_o = 0, data_o = 0, ovf_o = 0.
- Stage 1 register holds s1_data, s1_hi, s1_ovf, s1_valid:
  - s1_data = data_i << shamt_i[1:0].
  - s1_ovf = OR of the top shamt_i[1:0] bits of data_i.
  - s1_hi = shamt_i[SW-1:2].
- Stage 2 register drives data_o, ovf_o and valid_o:
  - shift s1_data left by 4*s1_hi.
  - ovf_o = s1_ovf | (OR of the bits shifted out).
  - If 4*s1_hi >= WIDTH: data_o = 0 and ovf_o = s1_ovf | (s1_data != 0).
- Latency: 2 cycles from an accepted input (valid_i & ready_o) to valid_o, assuming ready_i is held high.
- Handshake:
  - s2_ready = ~valid_o | ready_i.
  - ready_o = ~s1_valid | s2_ready.
  - Stage 1 loads when valid_i & ready_o; otherwise s1_valid clears if stage 1 moved forward.
  - Stage 2 loads from stage 1 when s1_valid & s2_ready; valid_o clears on ready_i with nothing moving forward.
  - Sustained throughput is one operand per cycle.
- Stability: while valid_o & ~ready_i, data_o, ovf_o and valid_o hold stable. ready_o may drop only when both stages are full.
- Simultaneous accept and drain: when a result leaves stage 2 in the same cycle a new input enters stage 1, no bubble is inserted and no data is lost.
- Data registers load only on their stage's load enable; they are not cleared on drain.
- Boundary values:
  - shamt_i = 0 passes data_i unchanged with ovf_o = 0.
  - shamt_i = WIDTH gives data_o = 0 and ovf_o = |data_i.
  - shamt_i > WIDTH gives the same result as WIDTH.
  - data_i = 0 gives data_o = 0 and ovf_o = 0 for any shift.
- Reset asserted mid-operation discards all in-flight operands immediately. valid_o is low in the first cycle after release.
- No combinational path from valid_i or data_i to any output. ready_o depends combinationally on ready_i only.

Test Plan:
- Basic and zero shift: reset, send data_i=16'h0003, shamt_i=4 with ready_i=1 -> valid_o 2 cycles later, data_o=16'h0030, ovf_o=0. Then data_i=16'hABCD, shamt_i=0 -> data_o=16'hABCD, ovf_o=0.
- Overflow:
  - data_i=16'h8001, shamt_i=1 -> data_o=16'h0002, ovf_o=1.
  - data_i=16'h0FFF, shamt_i=4 -> data_o=16'hFFF0, ovf_o=0.
  - data_i=16'h1FFF, shamt_i=4 -> data_o=16'hFFF0, ovf_o=1.
- Saturating shifts:
  - shamt_i=16 with data_i=16'h0001 -> data_o=0, ovf_o=1.
  - shamt_i=31 with data_i=16'h0000 -> data_o=0, ovf_o=0.
  - shamt_i=17 with data_i=16'h0002 -> data_o=0, ovf_o=1.
- Backpressure: stream 5 operands (data=1, shamt=0..4) back-to-back with ready_i low for cycles 2-5 -> ready_o falls after 2 accepts, data_o holds 16'h0001 while stalled, and after release outputs arrive in order 1,2,4,8,16 with no loss or duplication.
- Full throughput: 100 random operands with valid_i and ready_i held at 1 -> one result per cycle matching a reference model of (data<<shamt, ovf).
- Reset mid-flight: two operands in flight, pulse rst_ni low asynchronously between clock edges -> valid_o=0, data_o=0, ovf_o=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/tz_restore16.sv
// -----------------------------------------------------------------------------
// tz_restore16
//
// Purpose:
//   Re-inserts trailing zeros into an operand, undoing the trailing-zero count
//   taken in the binary GCD datapath. The block performs a logical left shift
//   (data_i << shamt_i), truncates the result to WIDTH bits, and flags any 1
//   bit that was pushed past the MSB. Any shift of WIDTH or more yields zero.
//
//   The shifter is a two-stage log shifter:
//     stage 1 : fine shift by shamt_i[1:0]   (0..3 positions)
//     stage 2 : coarse shift by 4*shamt_i[SW-1:2]
//   Each stage has its own valid bit. A valid/ready handshake runs at full
//   throughput, and a result can leave stage 2 in the same cycle that a new
//   operand enters stage 1.
//
// Ports:
//   clk_i    in   1      clock, rising edge
//   rst_ni   in   1      asynchronous active-low reset
//   valid_i  in   1      input operand valid
//   ready_o  out  1      block accepts an operand this cycle
//   data_i   in   WIDTH  operand to shift
//   shamt_i  in   SW     number of zeros to append (0..2^SW-1)
//   valid_o  out  1      result valid
//   ready_i  in   1      downstream accepts the result
//   data_o   out  WIDTH  (data_i << shamt_i) truncated to WIDTH bits
//   ovf_o    out  1      at least one 1 bit was shifted past the MSB
// -----------------------------------------------------------------------------
module tz_restore16 #(
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SW-1:0]    shamt_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ovf_o
);

    // Width of the coarse shift select (shift amount in units of 4 bits).
    localparam int            HW       = SW - 2;
    localparam logic [SW-1:0] LP_WIDTH = SW'(WIDTH);

    // Reject parameter sets the shifter structure cannot support.
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("tz_restore16: WIDTH must be a power of two and at least 4");
    end
    if (SW < $clog2(WIDTH) + 1) begin : g_bad_sw
        $error("tz_restore16: SW too narrow to represent a shift of WIDTH");
    end

    // -------------------------------------------------------------------------
    // Fine shift by 0..3 positions.
    // Returns {ovf, data}: the operand is widened by three guard bits so the
    // bits leaving the top end up in the guard field and can be OR-reduced.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH:0] shift_fine(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       sh
    );
        logic [WIDTH+2:0] ext;
        ext = {3'b000, d} << sh;
        return {|ext[WIDTH+2:WIDTH], ext[WIDTH-1:0]};
    endfunction

    // -------------------------------------------------------------------------
    // Coarse shift by 4*hi positions, merging the stage-1 overflow.
    // Returns {ovf, data}. A coarse shift of WIDTH or more saturates: the
    // result is zero and every remaining set bit counts as overflow.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH:0] shift_coarse(
        input logic [WIDTH-1:0] d,
        input logic [HW-1:0]    hi,
        input logic             ovf_in
    );
        logic [2*WIDTH-1:0] ext;
        logic [SW-1:0]      amt;
        amt = {hi, 2'b00};
        ext = {{WIDTH{1'b0}}, d} << amt;
        if (amt >= LP_WIDTH) begin
            return {ovf_in | (|d), {WIDTH{1'b0}}};
        end
        return {ovf_in | (|ext[2*WIDTH-1:WIDTH]), ext[WIDTH-1:0]};
    endfunction

    // Stage 1 registers
    logic [WIDTH-1:0] r_data_p1;
    logic [HW-1:0]    r_hi_p1;
    logic             r_ovf_p1;
    logic             r_vld_p1;

    // Stage 2 registers (drive the outputs)
    logic [WIDTH-1:0] r_data_p2;
    logic             r_ovf_p2;
    logic             r_vld_p2;

    // Handshake and datapath wires
    logic             w_s2_ready;
    logic             w_ld_p1;
    logic             w_ld_p2;
    logic [WIDTH:0]   w_fine;
    logic [WIDTH:0]   w_coarse;

    // Stage 2 can take new data when it is empty or its result is leaving.
    // ready_o therefore depends combinationally on ready_i only.
    assign w_s2_ready = ~r_vld_p2 | ready_i;
    assign ready_o    = ~r_vld_p1 | w_s2_ready;
    assign w_ld_p1    = valid_i & ready_o;
    assign w_ld_p2    = r_vld_p1 & w_s2_ready;

    assign w_fine     = shift_fine(data_i, shamt_i[1:0]);
    assign w_coarse   = shift_coarse(r_data_p1, r_hi_p1, r_ovf_p1);

    // ---- stage 0 -> stage 1 boundary --------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p1 <= 1'b0;
        end else if (w_ld_p1) begin
            r_vld_p1 <= 1'b1;
        end else if (w_ld_p2) begin
            r_vld_p1 <= 1'b0;
        end
    end

    // Stage-1 payload is only ever observed while r_vld_p1 is set, so it
    // needs no reset; it changes only when a new operand is accepted.
    always_ff @(posedge clk_i) begin
        if (w_ld_p1) begin
            r_data_p1 <= w_fine[WIDTH-1:0];
            r_ovf_p1  <= w_fine[WIDTH];
            r_hi_p1   <= shamt_i[SW-1:2];
        end
    end

    // ---- stage 1 -> stage 2 boundary --------------------------------------
    // The output payload is cleared by reset so data_o/ovf_o read zero while
    // in reset; otherwise it loads only when stage 1 moves forward and holds
    // through a stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_ovf_p2  <= 1'b0;
        end else if (w_ld_p2) begin
            r_vld_p2  <= 1'b1;
            r_data_p2 <= w_coarse[WIDTH-1:0];
            r_ovf_p2  <= w_coarse[WIDTH];
        end else if (ready_i) begin
            r_vld_p2  <= 1'b0;
        end
    end

    assign valid_o = r_vld_p2;
    assign data_o  = r_data_p2;
    assign ovf_o   = r_ovf_p2;

endmodule

// File: tb/tb_tz_restore16.sv
// -----------------------------------------------------------------------------
// tb_tz_restore16
//
// Self-checking bench for tz_restore16: a table of directed vectors with
// hand-computed results, followed by hand-written sequences for backpressure,
// sustained throughput against a reference model, and reset while operands
// are in flight.
// -----------------------------------------------------------------------------
module tb_tz_restore16;

    localparam int WIDTH = 16;
    localparam int SW    = 5;
    localparam int N_VEC = 17;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic [SW-1:0]    shamt_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] data_o;
    logic             ovf_o;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] d;
        logic [4:0]  s;
        logic [15:0] exp_d;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [N_VEC];

    tz_restore16 #(.WIDTH(WIDTH), .SW(SW)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .shamt_i (shamt_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    endtask

    // Reference: widen to 64 bits, shift, split into kept and lost bits.
    function automatic logic [16:0] ref_model(input logic [15:0] d, input logic [4:0] s);
        logic [63:0] ext;
        ext = {48'd0, d} << s;
        return {|ext[63:16], ext[15:0]};
    endfunction

    task automatic drain();
        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    // Global safety net in case a wait is ever unbounded by mistake.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] got [$];
        logic [16:0] exp_q [$];
        logic [16:0] e;
        int          acc;
        int          sent;
        int          cycles;
        int          low_rdy;
        int          waited;
        int          stale;

        vecs = '{
            '{16'h0003, 5'd4,  16'h0030, 1'b0},
            '{16'hABCD, 5'd0,  16'hABCD, 1'b0},
            '{16'h8001, 5'd1,  16'h0002, 1'b1},
            '{16'h0FFF, 5'd4,  16'hFFF0, 1'b0},
            '{16'h1FFF, 5'd4,  16'hFFF0, 1'b1},
            '{16'h0001, 5'd16, 16'h0000, 1'b1},
            '{16'h0000, 5'd31, 16'h0000, 1'b0},
            '{16'h0002, 5'd17, 16'h0000, 1'b1},
            '{16'h1234, 5'd3,  16'h91A0, 1'b0},
            '{16'hF000, 5'd3,  16'h8000, 1'b1},
            '{16'h00FF, 5'd8,  16'hFF00, 1'b0},
            '{16'h00FF, 5'd9,  16'hFE00, 1'b1},
            '{16'h0001, 5'd15, 16'h8000, 1'b0},
            '{16'h8000, 5'd15, 16'h0000, 1'b1},
            '{16'hFFFF, 5'd31, 16'h0000, 1'b1},
            '{16'h0003, 5'd14, 16'hC000, 1'b0},
            '{16'h0007, 5'd14, 16'hC000, 1'b1}
        };

        // ---------------- reset state ----------------
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        shamt_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_valid_o", valid_o, 1'b0);
        chk("reset_data_o",  data_o,  16'h0000);
        chk("reset_ovf_o",   ovf_o,   1'b0);
        chk("reset_ready_o", ready_o, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // ---------------- directed vector table ----------------
        // Operand presented in cycle N is captured by stage 1 at the end of
        // N and by stage 2 at the end of N+1, so valid_o is seen one edge
        // after the accepting edge (cycle N+2).
        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1;
            ready_i = 1'b1;
            data_i  = vecs[i].d;
            shamt_i = vecs[i].s;
            @(posedge clk_i);
            #1;
            valid_i = 1'b0;
            waited  = 0;
            while (!valid_o && waited < 8) begin
                @(posedge clk_i);
                #1;
                waited++;
            end
            chk($sformatf("vec%0d_latency", i), waited, 1);
            chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_d);
            chk($sformatf("vec%0d_ovf", i),  ovf_o,  vecs[i].exp_ovf);
        end
        drain();

        // ---------------- backpressure ----------------
        // data=1, shamt=0..4; ready_i low for cycles 2..5.
        acc = 0;
        got.delete();
        for (int c = 1; c <= 40 && got.size() < 5; c++) begin
            @(negedge clk_i);
            ready_i = !(c >= 2 && c <= 5);
            valid_i = (acc < 5);
            data_i  = 16'h0001;
            shamt_i = 5'(acc);
            #1;
            if (c == 3) begin
                chk("bp_accepts_before_stall", acc, 2);
                chk("bp_ready_low", ready_o, 1'b0);
            end
            if (c >= 3 && c <= 5) begin
                chk($sformatf("bp_hold_valid_c%0d", c), valid_o, 1'b1);
                chk($sformatf("bp_hold_data_c%0d", c),  data_o,  16'h0001);
                chk($sformatf("bp_hold_ovf_c%0d", c),   ovf_o,   1'b0);
            end
            if (valid_o && ready_i) got.push_back(data_o);
            if (valid_i && ready_o) acc++;
            @(posedge clk_i);
        end
        valid_i = 1'b0;
        chk("bp_result_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 16'hDEAD,
                16'(1 << i));
        end
        drain();

        // ---------------- full throughput ----------------
        sent    = 0;
        cycles  = 0;
        low_rdy = 0;
        exp_q.delete();
        for (int c = 0; c < 300 && (sent < 100 || exp_q.size() > 0); c++) begin
            @(negedge clk_i);
            ready_i = 1'b1;
            valid_i = (sent < 100);
            case ($urandom_range(0, 3))
                0:       data_i = 16'h0000;
                1:       data_i = 16'(1 << $urandom_range(0, 15));
                default: data_i = 16'($urandom);
            endcase
            shamt_i = 5'($urandom_range(0, 31));
            #1;
            if (!ready_o) low_rdy++;
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("tp_spurious_valid", valid_o, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tp_result", {ovf_o, data_o}, e);
                end
            end
            if (valid_i && ready_o) begin
                exp_q.push_back(ref_model(data_i, shamt_i));
                sent++;
            end
            cycles++;
            @(posedge clk_i);
        end
        valid_i = 1'b0;
        chk("tp_sent", sent, 100);
        chk("tp_ready_low_cycles", low_rdy, 0);
        chk("tp_total_cycles", cycles, 102);
        drain();

        // ---------------- reset mid-flight ----------------
        @(negedge clk_i);
        valid_i = 1'b1;
        ready_i = 1'b1;
        data_i  = 16'h00F0;
        shamt_i = 5'd2;
        @(posedge clk_i);
        #1;
        data_i  = 16'h0F0F;
        shamt_i = 5'd8;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("rst_pre_valid", valid_o, 1'b1);
        chk("rst_pre_data",  data_o,  16'h03C0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_async_valid", valid_o, 1'b0);
        chk("rst_async_data",  data_o,  16'h0000);
        chk("rst_async_ovf",   ovf_o,   1'b0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        stale  = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) stale++;
        end
        chk("rst_no_stale_result", stale, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
